tile_scheduler: RTL and testbench

- Sequences the systolic core through a full M×N×K GEMM using the tile geometry programmed in the CSR block (M/N/K, Tm/Tn/Tk).
- Consumes the CSR start/abort pulses.
- Drives the buffer loader and core tile-start per tile; manages ping-pong bank selection; emits m/n/k tile indices; reports busy/done back to CSR.
- Sits between csr and the loader/core datapath.

---
 rtl/tile_scheduler_if.sv | 54 +++++
 rtl/tile_scheduler.sv | 222 ++++++++++++++++++++++
 tb/tb_tile_scheduler.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/tile_scheduler_if.sv
// ============================================================================
// Module      : tile_scheduler_if
// Description : CSR-side and datapath-side signal bundle of the tile scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface tile_scheduler_if #(
    parameter int DIM_W  = 16,
    parameter int TILE_W = 8
);
    logic              start_pulse;
    logic              abort_pulse;
    logic [DIM_W-1:0]  M;
    logic [DIM_W-1:0]  N;
    logic [DIM_W-1:0]  K;
    logic [TILE_W-1:0] Tm;
    logic [TILE_W-1:0] Tn;
    logic [TILE_W-1:0] Tk;
    logic              load_req;
    logic              load_bank;
    logic              load_done;
    logic              tile_start;
    logic              rd_bank;
    logic              last_k;
    logic              core_done_tile_pulse;
    logic [DIM_W-1:0]  m_idx;
    logic [DIM_W-1:0]  n_idx;
    logic [DIM_W-1:0]  k_idx;
    logic [TILE_W-1:0] len_m;
    logic [TILE_W-1:0] len_n;
    logic [TILE_W-1:0] len_k;
    logic              busy;
    logic              done_pulse;
    logic              cfg_error;

    modport master (
        input  start_pulse, abort_pulse, M, N, K, Tm, Tn, Tk,
        input  load_done, core_done_tile_pulse,
        output load_req, load_bank, tile_start, rd_bank, last_k,
        output m_idx, n_idx, k_idx, len_m, len_n, len_k,
        output busy, done_pulse, cfg_error
    );

    modport slave (
        output start_pulse, abort_pulse, M, N, K, Tm, Tn, Tk,
        output load_done, core_done_tile_pulse,
        input  load_req, load_bank, tile_start, rd_bank, last_k,
        input  m_idx, n_idx, k_idx, len_m, len_n, len_k,
        input  busy, done_pulse, cfg_error
    );
endinterface

`default_nettype wire

// File: rtl/tile_scheduler.sv
// ============================================================================
// Module      : tile_scheduler
// Description : Walks an MxNxK GEMM tile by tile (k innermost), handshaking
//               with the buffer loader and systolic core, ping-ponging banks.
//               Optional macro TILE_SCHED_PERF_EN adds performance counters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tile_scheduler #(
    parameter int DIM_W  = 16,
    parameter int TILE_W = 8
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    tile_scheduler_if.master  bus
`ifdef TILE_SCHED_PERF_EN
    ,
    output logic [31:0]       tiles_issued,
    output logic [31:0]       load_stall_cycles
`endif
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD    = 3'd1,
        S_ISSUE   = 3'd2,
        S_WAIT    = 3'd3,
        S_ADVANCE = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    state_t            state_q;
    logic              load_req_q;
    logic              load_bank_q;
    logic              tile_start_q;
    logic              rd_bank_q;
    logic              last_k_q;
    logic              busy_q;
    logic              done_pulse_q;
    logic              cfg_error_q;
    logic [DIM_W-1:0]  m_idx_q, n_idx_q, k_idx_q;
    logic [DIM_W-1:0]  dim_m_q, dim_n_q, dim_k_q;
    logic [TILE_W-1:0] tm_q, tn_q, tk_q;

    logic              cfg_zero;
    logic              start_accept;
    logic              abort_active;
    logic [DIM_W:0]    m_sum, n_sum, k_sum;
    logic              m_wrap, n_wrap, k_wrap;

    function automatic logic [TILE_W-1:0] clip_len(
        input logic [DIM_W-1:0]  dim,
        input logic [DIM_W-1:0]  idx,
        input logic [TILE_W-1:0] tsz
    );
        logic [DIM_W-1:0] rem;
        rem = dim - idx;
        if (rem < DIM_W'(tsz)) clip_len = rem[TILE_W-1:0];
        else                   clip_len = tsz;
    endfunction

    assign cfg_zero = (bus.M == '0) || (bus.N == '0) || (bus.K == '0) ||
                      (bus.Tm == '0) || (bus.Tn == '0) || (bus.Tk == '0);

    // Abort has priority over every other event, including a coincident start.
    assign abort_active = bus.abort_pulse && (state_q != S_IDLE);
    assign start_accept = (state_q == S_IDLE) && bus.start_pulse &&
                          !bus.abort_pulse && !cfg_zero;

    // One extra bit keeps e.g. 0xFFFF + 0xFF from aliasing below the bound.
    assign k_sum  = {1'b0, k_idx_q} + (DIM_W+1)'(tk_q);
    assign n_sum  = {1'b0, n_idx_q} + (DIM_W+1)'(tn_q);
    assign m_sum  = {1'b0, m_idx_q} + (DIM_W+1)'(tm_q);
    assign k_wrap = (k_sum >= {1'b0, dim_k_q});
    assign n_wrap = (n_sum >= {1'b0, dim_n_q});
    assign m_wrap = (m_sum >= {1'b0, dim_m_q});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            load_req_q   <= 1'b0;
            load_bank_q  <= 1'b0;
            tile_start_q <= 1'b0;
            rd_bank_q    <= 1'b0;
            last_k_q     <= 1'b0;
            busy_q       <= 1'b0;
            done_pulse_q <= 1'b0;
            cfg_error_q  <= 1'b0;
            m_idx_q      <= '0;
            n_idx_q      <= '0;
            k_idx_q      <= '0;
            dim_m_q      <= '0;
            dim_n_q      <= '0;
            dim_k_q      <= '0;
            tm_q         <= '0;
            tn_q         <= '0;
            tk_q         <= '0;
        end else begin
            tile_start_q <= 1'b0;
            done_pulse_q <= 1'b0;
            if (abort_active) begin
                state_q    <= S_IDLE;
                load_req_q <= 1'b0;
                busy_q     <= 1'b0;
                m_idx_q    <= '0;
                n_idx_q    <= '0;
                k_idx_q    <= '0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (bus.start_pulse && !bus.abort_pulse) begin
                            if (cfg_zero) begin
                                cfg_error_q <= 1'b1;
                            end else begin
                                dim_m_q     <= bus.M;
                                dim_n_q     <= bus.N;
                                dim_k_q     <= bus.K;
                                tm_q        <= bus.Tm;
                                tn_q        <= bus.Tn;
                                tk_q        <= bus.Tk;
                                cfg_error_q <= 1'b0;
                                m_idx_q     <= '0;
                                n_idx_q     <= '0;
                                k_idx_q     <= '0;
                                load_bank_q <= 1'b0;
                                load_req_q  <= 1'b1;
                                busy_q      <= 1'b1;
                                state_q     <= S_LOAD;
                            end
                        end
                    end
                    S_LOAD: begin
                        if (bus.load_done) begin
                            load_req_q   <= 1'b0;
                            tile_start_q <= 1'b1;
                            rd_bank_q    <= load_bank_q;
                            last_k_q     <= k_wrap;
                            state_q      <= S_ISSUE;
                        end
                    end
                    S_ISSUE: begin
                        state_q <= S_WAIT;
                    end
                    S_WAIT: begin
                        if (bus.core_done_tile_pulse) state_q <= S_ADVANCE;
                    end
                    S_ADVANCE: begin
                        load_bank_q <= ~load_bank_q;
                        if (!k_wrap) begin
                            k_idx_q <= k_sum[DIM_W-1:0];
                        end else begin
                            k_idx_q <= '0;
                            if (!n_wrap) begin
                                n_idx_q <= n_sum[DIM_W-1:0];
                            end else begin
                                n_idx_q <= '0;
                                m_idx_q <= m_wrap ? '0 : m_sum[DIM_W-1:0];
                            end
                        end
                        if (k_wrap && n_wrap && m_wrap) begin
                            done_pulse_q <= 1'b1;
                            busy_q       <= 1'b0;
                            state_q      <= S_DONE;
                        end else begin
                            load_req_q <= 1'b1;
                            state_q    <= S_LOAD;
                        end
                    end
                    S_DONE: begin
                        state_q <= S_IDLE;
                    end
                    default: begin
                        state_q <= S_IDLE;
                    end
                endcase
            end
        end
    end

`ifdef TILE_SCHED_PERF_EN
    logic [31:0] tiles_issued_q;
    logic [31:0] load_stall_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tiles_issued_q <= '0;
            load_stall_q   <= '0;
        end else if (start_accept) begin
            tiles_issued_q <= '0;
            load_stall_q   <= '0;
        end else if (state_q == S_LOAD) begin
            load_stall_q <= load_stall_q + 32'd1;
            if (bus.load_done && !bus.abort_pulse) tiles_issued_q <= tiles_issued_q + 32'd1;
        end
    end

    assign tiles_issued      = tiles_issued_q;
    assign load_stall_cycles = load_stall_q;
`else
    logic unused_start_accept;
    assign unused_start_accept = start_accept;
`endif

    assign bus.load_req   = load_req_q;
    assign bus.load_bank  = load_bank_q;
    assign bus.tile_start = tile_start_q;
    assign bus.rd_bank    = rd_bank_q;
    assign bus.last_k     = last_k_q;
    assign bus.busy       = busy_q;
    assign bus.done_pulse = done_pulse_q;
    assign bus.cfg_error  = cfg_error_q;
    assign bus.m_idx      = m_idx_q;
    assign bus.n_idx      = n_idx_q;
    assign bus.k_idx      = k_idx_q;
    assign bus.len_m      = clip_len(dim_m_q, m_idx_q, tm_q);
    assign bus.len_n      = clip_len(dim_n_q, n_idx_q, tn_q);
    assign bus.len_k      = clip_len(dim_k_q, k_idx_q, tk_q);

endmodule

`default_nettype wire

// File: tb/tb_tile_scheduler.sv
// ============================================================================
// Module      : tb_tile_scheduler
// Description : Directed scoreboard bench for tile_scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tile_scheduler;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    tile_scheduler_if #(.DIM_W(16), .TILE_W(8)) bus ();

`ifdef TILE_SCHED_PERF_EN
    logic [31:0] tiles_issued;
    logic [31:0] load_stall_cycles;
`endif

    tile_scheduler #(.DIM_W(16), .TILE_W(8)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
`ifdef TILE_SCHED_PERF_EN
        ,
        .tiles_issued      (tiles_issued),
        .load_stall_cycles (load_stall_cycles)
`endif
    );

    typedef struct {
        int m, n, k, lm, ln, lk;
        bit last;
    } tile_t;

    tile_t sb[$];
    int    checks   = 0;
    int    failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_cfg(input int m, input int n, input int k,
                           input int tm, input int tn, input int tk);
        bus.M  = 16'(m);  bus.N  = 16'(n);  bus.K  = 16'(k);
        bus.Tm = 8'(tm);  bus.Tn = 8'(tn);  bus.Tk = 8'(tk);
    endtask

    // Expected tile list from a straightforward nested-loop walk of the problem.
    task automatic push_job(input int m_dim, input int n_dim, input int k_dim,
                            input int tm, input int tn, input int tk);
        tile_t t;
        for (int m = 0; m < m_dim; m += tm)
            for (int n = 0; n < n_dim; n += tn)
                for (int k = 0; k < k_dim; k += tk) begin
                    t.m = m; t.n = n; t.k = k;
                    t.lm = (m_dim - m < tm) ? m_dim - m : tm;
                    t.ln = (n_dim - n < tn) ? n_dim - n : tn;
                    t.lk = (k_dim - k < tk) ? k_dim - k : tk;
                    t.last = (k + tk >= k_dim);
                    sb.push_back(t);
                end
    endtask

    task automatic pulse_start();
        bus.start_pulse = 1'b1;
        @(negedge clk);
        bus.start_pulse = 1'b0;
    endtask

    // Entered at the negedge right after start was sampled.
    task automatic serve_job(input int abort_at, input bit disturb,
                             output int ntiles, output int ndone);
        tile_t e;
        int    t = 0;
        ndone = 0;
        while (t < 40) begin
            chk("load_req_rise", {31'b0, bus.load_req}, 32'd1);
            if (bus.load_req !== 1'b1) break;
            chk("load_bank", {31'b0, bus.load_bank}, 32'(t % 2));
            for (int w = 0; w < 2; w++) begin
                if (disturb && t == 1 && w == 0) begin
                    bus.start_pulse          = 1'b1;
                    bus.core_done_tile_pulse = 1'b1;
                end
                @(negedge clk);
                bus.start_pulse          = 1'b0;
                bus.core_done_tile_pulse = 1'b0;
                chk("load_req_hold", {31'b0, bus.load_req}, 32'd1);
            end
            bus.load_done = 1'b1;
            @(negedge clk);
            bus.load_done = 1'b0;
            chk("tile_start_lat", {31'b0, bus.tile_start}, 32'd1);
            chk("rd_bank", {31'b0, bus.rd_bank}, 32'(t % 2));
            if (sb.size() == 0) begin
                chk("sb_underflow", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("m_idx",  32'(bus.m_idx), 32'(e.m));
                chk("n_idx",  32'(bus.n_idx), 32'(e.n));
                chk("k_idx",  32'(bus.k_idx), 32'(e.k));
                chk("len_m",  32'(bus.len_m), 32'(e.lm));
                chk("len_n",  32'(bus.len_n), 32'(e.ln));
                chk("len_k",  32'(bus.len_k), 32'(e.lk));
                chk("last_k", {31'b0, bus.last_k}, {31'b0, e.last});
            end
            t++;
            @(negedge clk);
            chk("tile_start_once", {31'b0, bus.tile_start}, 32'd0);
            chk("busy_mid", {31'b0, bus.busy}, 32'd1);
            if (t == abort_at) begin
                bus.abort_pulse = 1'b1;
                @(negedge clk);
                bus.abort_pulse = 1'b0;
                chk("abort_busy", {31'b0, bus.busy}, 32'd0);
                chk("abort_load_req", {31'b0, bus.load_req}, 32'd0);
                chk("abort_m_idx", 32'(bus.m_idx), 32'd0);
                for (int i = 0; i < 4; i++) begin
                    if (bus.done_pulse === 1'b1) ndone++;
                    @(negedge clk);
                end
                break;
            end
            @(negedge clk);
            bus.core_done_tile_pulse = 1'b1;
            @(negedge clk);
            bus.core_done_tile_pulse = 1'b0;
            @(negedge clk);
            if (bus.done_pulse === 1'b1) begin
                ndone++;
                chk("busy_at_done", {31'b0, bus.busy}, 32'd0);
                @(negedge clk);
                chk("done_one_cycle", {31'b0, bus.done_pulse}, 32'd0);
                break;
            end
        end
        ntiles = t;
    endtask

    int nt, nd;

    initial begin
        bus.start_pulse          = 1'b0;
        bus.abort_pulse          = 1'b0;
        bus.load_done            = 1'b0;
        bus.core_done_tile_pulse = 1'b0;
        set_cfg(0, 0, 0, 0, 0, 0);
        repeat (3) @(negedge clk);
        chk("rst_load_req",   {31'b0, bus.load_req},   32'd0);
        chk("rst_tile_start", {31'b0, bus.tile_start}, 32'd0);
        chk("rst_busy",       {31'b0, bus.busy},       32'd0);
        chk("rst_done",       {31'b0, bus.done_pulse}, 32'd0);
        chk("rst_cfg_error",  {31'b0, bus.cfg_error},  32'd0);
        chk("rst_banks",      {30'b0, bus.load_bank, bus.rd_bank}, 32'd0);
        chk("rst_m_idx",      32'(bus.m_idx), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Scenario 1: 4x4x4 with 2x2x2 tiles; CSR rewritten mid-job.
        set_cfg(4, 4, 4, 2, 2, 2);
        push_job(4, 4, 4, 2, 2, 2);
        pulse_start();
        set_cfg(9, 1, 1, 1, 1, 1);
        serve_job(0, 1'b0, nt, nd);
        chk("s1_tiles", 32'(nt), 32'd8);
        chk("s1_done_cnt", 32'(nd), 32'd1);
        chk("s1_sb_empty", 32'(sb.size()), 32'd0);
        chk("s1_busy_after", {31'b0, bus.busy}, 32'd0);
`ifdef TILE_SCHED_PERF_EN
        chk("perf_tiles_issued", tiles_issued, 32'd8);
`endif

        // Invalid config: abort+start together ignored, then plain start flags error.
        set_cfg(4, 4, 4, 2, 2, 0);
        bus.abort_pulse = 1'b1;
        pulse_start();
        bus.abort_pulse = 1'b0;
        chk("abort_start_idle_err", {31'b0, bus.cfg_error}, 32'd0);
        chk("abort_start_idle_busy", {31'b0, bus.busy}, 32'd0);
        pulse_start();
        chk("cfg_error_set", {31'b0, bus.cfg_error}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            chk("cfg_err_busy", {31'b0, bus.busy}, 32'd0);
            chk("cfg_err_load_req", {31'b0, bus.load_req}, 32'd0);
            @(negedge clk);
        end

        // Scenario 2: edge-clipped tiles, with spurious start/core_done during LOAD.
        set_cfg(5, 3, 7, 2, 2, 4);
        push_job(5, 3, 7, 2, 2, 4);
        pulse_start();
        chk("cfg_error_clear", {31'b0, bus.cfg_error}, 32'd0);
        serve_job(0, 1'b1, nt, nd);
        chk("s2_tiles", 32'(nt), 32'd12);
        chk("s2_done_cnt", 32'(nd), 32'd1);
        chk("s2_sb_empty", 32'(sb.size()), 32'd0);

        // Scenario 3: abort in WAIT of tile 3, then a clean restart.
        set_cfg(4, 4, 4, 2, 2, 2);
        push_job(4, 4, 4, 2, 2, 2);
        pulse_start();
        serve_job(3, 1'b0, nt, nd);
        chk("s3_tiles_before_abort", 32'(nt), 32'd3);
        chk("s3_no_done", 32'(nd), 32'd0);
        sb.delete();
        push_job(4, 4, 4, 2, 2, 2);
        pulse_start();
        serve_job(0, 1'b0, nt, nd);
        chk("s3_restart_tiles", 32'(nt), 32'd8);
        chk("s3_restart_done", 32'(nd), 32'd1);
        chk("s3_sb_empty", 32'(sb.size()), 32'd0);

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
